// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receive path. Samples the asynchronous rxd pin through a
//   two-flop synchroniser, finds the start bit on a falling edge, samples
//   each bit at its centre using a shared down-counter, and hands completed
//   bytes to a holding buffer that the CPU drains with rd_en. Framing and
//   overrun errors are reported through sticky flags cleared by err_clr.
//
//   Optional feature: define UART_RX_FIFO_EN to replace the single holding
//   register with a FIFO_DEPTH-entry FIFO.
//
// Parameters
//   CLK_FREQ_HZ  clk frequency in Hz
//   BAUD_RATE    line rate in bit/s (CLK_FREQ_HZ/BAUD_RATE must be >= 4)
//   FIFO_DEPTH   FIFO entries, power of 2, >= 2 (UART_RX_FIFO_EN only)
//
// Ports
//   clk          system clock
//   resetn       synchronous, active-low reset
//   rxd          serial input, asynchronous, idle high
//   rd_en        one-cycle pulse: consume the current byte
//   err_clr      one-cycle pulse: clear the sticky error flags
//   o_data       received byte (head of buffer)
//   o_valid      o_data holds an unread byte
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a byte was dropped because the buffer was full
//   o_busy       receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int unsigned CLK_FREQ_HZ = 16000000,
  parameter int unsigned BAUD_RATE   = 1000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic             fall_edge;
  logic             deliver, frame_err_set, overrun_set;
  logic             frame_err_q, overrun_q;

  // Input synchroniser; idle-high reset so no false edge after reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Only a high-to-low transition starts a frame, so a held-low line
  // (break) cannot retrigger reception.
  assign fall_edge = rx_prev_q & ~rx_s_q;

  // Receive FSM: next state and datapath
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    deliver       = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          cnt_d   = HALF_M1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            cnt_d     = DIV_M1;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;  // glitch, not a real start bit
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          cnt_d     = DIV_M1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) deliver = 1'b1;
          else        frame_err_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign o_busy = (state_q != IDLE);

  // Sticky flags: a new error in the same cycle as err_clr wins
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_set | (frame_err_q & ~err_clr);
      overrun_q   <= overrun_set   | (overrun_q   & ~err_clr);
    end
  end

  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop;

  // Extra wrap bit distinguishes full from empty when indices match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop         = rd_en & ~empty;
  // When full, a same-cycle pop frees the head slot the push overwrites
  assign push        = deliver & (~full | rd_en);
  assign overrun_set = deliver & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= shift_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign o_data  = mem_q[rd_ptr_q[PW-1:0]];
  assign o_valid = ~empty;
`else
  localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] data_q;
  logic       valid_q;

  assign overrun_set = deliver & valid_q & ~rd_en;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (deliver) begin
      if (!valid_q || rd_en) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end
    end else if (rd_en) begin
      valid_q <= 1'b0;  // o_data keeps its stale value
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver at 16 MHz / 1 Mbit/s (DIV=16).
//   A table of single frames is applied in a loop, followed by hand-written
//   sequences for glitches, overrun, mid-frame reset, error-clear priority
//   and a read landing in the exact delivery cycle.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int unsigned CLK_FREQ_HZ = 16000000;
  localparam int unsigned BAUD_RATE   = 1000000;
  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF  = DIV / 2;
  localparam int FRAME = 10 * DIV;
  localparam int LAT   = 2 + HALF + 9 * DIV + 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overrun, o_busy;

  int ntests = 0;
  int nfail  = 0;
  int lat    = 0;

  uart_receiver #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives the first ncyc cycles of a frame. rd_en / err_clr pulse when the
  // cycle index equals rd_at / clr_at, so they are sampled at edge index+1.
  // lat records the first edge after which o_valid is seen high.
  task automatic send_cycles(input logic [7:0] data, input logic stop, input int ncyc,
                             input int rd_at, input int clr_at);
    int b;
    lat = 0;
    for (int c = 0; c < ncyc; c++) begin
      b = c / DIV;
      if (b == 0)      rxd = 1'b0;
      else if (b <= 8) rxd = data[b-1];
      else             rxd = stop;
      rd_en   = (c == rd_at);
      err_clr = (c == clr_at);
      tick();
      if (o_valid && lat == 0) lat = c + 1;
    end
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rxd     = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_cycles(data, stop, FRAME, -1, -1);
    tick();
  endtask

  task automatic drain();
    rd_en   = 1'b1;
    err_clr = 1'b1;
    tick();
    rd_en   = 1'b0;
    err_clr = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};

    if (DIV < 4) $display("[TB] configuration error: DIV=%0d is below 4", DIV);

    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    chk("reset_data",  o_data,      8'h00);
    chk("reset_valid", o_valid,     1'b0);
    chk("reset_ferr",  o_frame_err, 1'b0);
    chk("reset_ovr",   o_overrun,   1'b0);
    chk("reset_busy",  o_busy,      1'b0);
    resetn = 1'b1;
    repeat (3) tick();

    // Table of single frames, each drained afterwards
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      chk($sformatf("vec%0d_valid", i), o_valid,     vecs[i].exp_valid);
      chk($sformatf("vec%0d_ferr", i),  o_frame_err, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovr", i),   o_overrun,   1'b0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_lat_ok", i), (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);
      end
      drain();
      chk($sformatf("vec%0d_valid_after_rd", i), o_valid,     1'b0);
      chk($sformatf("vec%0d_ferr_after_clr", i), o_frame_err, 1'b0);
    end

    // Start-bit glitch: 4 low cycles then high
    rxd = 1'b0;
    repeat (4) tick();
    chk("glitch_busy_high", o_busy, 1'b1);
    rxd = 1'b1;
    repeat (20) tick();
    chk("glitch_busy_low", o_busy,      1'b0);
    chk("glitch_valid",    o_valid,     1'b0);
    chk("glitch_ferr",     o_frame_err, 1'b0);
    chk("glitch_ovr",      o_overrun,   1'b0);

    // Frame error with err_clr in the same cycle: set wins
    send_cycles(8'hA3, 1'b0, FRAME, -1, LAT - 1);
    tick();
    chk("ferr_set_wins", o_frame_err, 1'b1);
    chk("ferr_no_valid", o_valid,     1'b0);
    drain();

    // Overrun
`ifdef UART_RX_FIFO_EN
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    chk("fifo_ovr", o_overrun, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fifo_pop%0d_valid", k), o_valid, 1'b1);
      chk($sformatf("fifo_pop%0d_data", k),  o_data,  8'(k));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("fifo_empty", o_valid, 1'b0);
    send_frame(8'h66, 1'b1);
`else
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    chk("ovr_data",  o_data,    8'h12);
    chk("ovr_valid", o_valid,   1'b1);
    chk("ovr_flag",  o_overrun, 1'b1);
`endif

    // Reset after 3 data bits; buffer and overrun flag are non-zero here
    send_cycles(8'hC3, 1'b1, 4 * DIV, -1, -1);
    rxd = 1'b0;
    chk("midframe_busy", o_busy, 1'b1);
    resetn = 1'b0;
    rxd = 1'b1;
    repeat (2) tick();
    chk("mreset_data",  o_data,      8'h00);
    chk("mreset_valid", o_valid,     1'b0);
    chk("mreset_ferr",  o_frame_err, 1'b0);
    chk("mreset_ovr",   o_overrun,   1'b0);
    chk("mreset_busy",  o_busy,      1'b0);
    resetn = 1'b1;
    repeat (3) tick();
    send_frame(8'hC3, 1'b1);
    chk("after_reset_data",  o_data,      8'hC3);
    chk("after_reset_valid", o_valid,     1'b1);
    chk("after_reset_ferr",  o_frame_err, 1'b0);
    chk("after_reset_ovr",   o_overrun,   1'b0);
    drain();

    // Back-to-back frames, rd_en in the delivery cycle of the second
    send_cycles(8'hAA, 1'b1, FRAME, -1, -1);
    chk("b2b_first_data", o_data, 8'hAA);
    send_cycles(8'hBB, 1'b1, FRAME, LAT - 1, -1);
    tick();
    chk("b2b_data",  o_data,    8'hBB);
    chk("b2b_valid", o_valid,   1'b1);
    chk("b2b_ovr",   o_overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
